// File: rtl/food_spawn_ctrl.sv
`default_nettype none
// food_spawn_ctrl: draws X/Y cells from the LFSR, range-checks them, asks body occupancy,
// retries on rejection and publishes the food pixel position. Optional macro: FOOD_TIMEOUT_EN.
module food_spawn_ctrl #(
  parameter int GRID_LOG2   = 4,
  parameter int X_CELLS     = 40,
  parameter int Y_CELLS     = 30,
  parameter int X_ORG       = 0,
  parameter int Y_ORG       = 0,
  parameter int MAX_TRIES   = 16,
  parameter int FALLBACK_X  = 320,
  parameter int FALLBACK_Y  = 240,
  parameter int RESET_X     = 320,
  parameter int RESET_Y     = 240,
  parameter int TIMEOUT_CYC = 250000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spawn_req,
  input  logic [8:0] rand_num,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic       occ_req,
  output logic [9:0] occ_x,
  output logic [9:0] occ_y,
  output logic [9:0] food_x,
  output logic [9:0] food_y,
  output logic       food_valid,
  output logic       spawn_busy,
  output logic       spawn_done,
  output logic       spawn_fail,
  output logic       food_expired
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAW_X = 2'd1,
    S_DRAW_Y = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  cand_x_q, cand_x_d;
  logic [15:0] tries_q, tries_d;
  logic [9:0]  occ_x_q, occ_x_d, occ_y_q, occ_y_d;
  logic [9:0]  food_x_q, food_x_d, food_y_q, food_y_d;
  logic        food_valid_q, food_valid_d;
  logic        spawn_done_q, spawn_done_d;
  logic        spawn_fail_q, spawn_fail_d;
  logic        food_expired_q, food_expired_d;
  logic        timeout_hit;
  logic        start;
  logic        reject;
  logic [31:0] pix_x, pix_y;

`ifdef FOOD_TIMEOUT_EN
  logic [27:0] idle_cnt_q, idle_cnt_d;

  assign timeout_hit = (state_q == S_IDLE) && food_valid_q &&
                       (idle_cnt_q == 28'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_cnt_d = 28'd0;
    if ((state_q == S_IDLE) && food_valid_q && !spawn_req && !timeout_hit)
      idle_cnt_d = idle_cnt_q + 28'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= 28'd0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
`endif

  assign start = (state_q == S_IDLE) && (spawn_req || timeout_hit);

  // Candidate pixel positions, truncated to the 10-bit screen coordinate.
  assign pix_x = 32'(X_ORG) + (32'(cand_x_q) << GRID_LOG2);
  assign pix_y = 32'(Y_ORG) + (32'(rand_num) << GRID_LOG2);

  always_comb begin
    state_d        = state_q;
    cand_x_d       = cand_x_q;
    tries_d        = tries_q;
    occ_x_d        = occ_x_q;
    occ_y_d        = occ_y_q;
    food_x_d       = food_x_q;
    food_y_d       = food_y_q;
    food_valid_d   = food_valid_q;
    spawn_done_d   = 1'b0;
    spawn_fail_d   = 1'b0;
    food_expired_d = 1'b0;
    reject         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_DRAW_X;
          food_valid_d   = 1'b0;
          tries_d        = 16'd0;
          food_expired_d = timeout_hit;
        end
      end
      S_DRAW_X: begin
        if (32'(rand_num) < X_CELLS) begin
          cand_x_d = rand_num;
          state_d  = S_DRAW_Y;
        end else begin
          reject = 1'b1;
        end
      end
      S_DRAW_Y: begin
        if (32'(rand_num) < Y_CELLS) begin
          occ_x_d = pix_x[9:0];
          occ_y_d = pix_y[9:0];
          state_d = S_CHECK;
        end else begin
          reject = 1'b1;
        end
      end
      default: begin
        if (occ_ack) begin
          if (occ_hit) begin
            reject = 1'b1;
          end else begin
            food_x_d     = occ_x_q;
            food_y_d     = occ_y_q;
            food_valid_d = 1'b1;
            spawn_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
    endcase

    // A rejected occupancy check restarts from the X draw; range rejects redraw in place.
    if (reject) begin
      if (tries_q == 16'(MAX_TRIES - 1)) begin
        food_x_d     = 10'(FALLBACK_X);
        food_y_d     = 10'(FALLBACK_Y);
        food_valid_d = 1'b1;
        spawn_done_d = 1'b1;
        spawn_fail_d = 1'b1;
        state_d      = S_IDLE;
      end else begin
        tries_d = tries_q + 16'd1;
        state_d = (state_q == S_CHECK) ? S_DRAW_X : state_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cand_x_q       <= 9'd0;
      tries_q        <= 16'd0;
      occ_x_q        <= 10'd0;
      occ_y_q        <= 10'd0;
      food_x_q       <= 10'(RESET_X);
      food_y_q       <= 10'(RESET_Y);
      food_valid_q   <= 1'b1;
      spawn_done_q   <= 1'b0;
      spawn_fail_q   <= 1'b0;
      food_expired_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_x_q       <= cand_x_d;
      tries_q        <= tries_d;
      occ_x_q        <= occ_x_d;
      occ_y_q        <= occ_y_d;
      food_x_q       <= food_x_d;
      food_y_q       <= food_y_d;
      food_valid_q   <= food_valid_d;
      spawn_done_q   <= spawn_done_d;
      spawn_fail_q   <= spawn_fail_d;
      food_expired_q <= food_expired_d;
    end
  end

  assign occ_req      = (state_q == S_CHECK);
  assign spawn_busy   = (state_q != S_IDLE);
  assign occ_x        = occ_x_q;
  assign occ_y        = occ_y_q;
  assign food_x       = food_x_q;
  assign food_y       = food_y_q;
  assign food_valid   = food_valid_q;
  assign spawn_done   = spawn_done_q;
  assign spawn_fail   = spawn_fail_q;
  assign food_expired = food_expired_q;

endmodule
`default_nettype wire

// File: tb/tb_food_spawn_ctrl.sv
`default_nettype none
// Bench for food_spawn_ctrl: directed vector table, reset-abort sequence, and random spawns
// checked against a draw/retry reference model.
module tb_food_spawn_ctrl;

  localparam int MAXJ = 512;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spawn_req = 1'b0;
  logic [8:0] rand_num = 9'd0;
  logic       occ_ack = 1'b0;
  logic       occ_hit = 1'b0;
  logic       occ_req, food_valid, spawn_busy, spawn_done, spawn_fail, food_expired;
  logic [9:0] occ_x, occ_y, food_x, food_y;

  food_spawn_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .spawn_req(spawn_req), .rand_num(rand_num),
    .occ_ack(occ_ack), .occ_hit(occ_hit), .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .spawn_busy(spawn_busy),
    .spawn_done(spawn_done), .spawn_fail(spawn_fail), .food_expired(food_expired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle stimulus for one spawn; index j is the j-th cycle after the request is taken.
  logic [8:0] rn_a [MAXJ];
  bit         ack_a[MAXJ];
  bit         hit_a[MAXJ];
  bit         chk_a[MAXJ];

  typedef struct {
    int rn[6];
    int hitm;
    int chkm;
    int ex;
    int ey;
    bit fail;
    int jlast;
    bit hold;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_cycle(input int j);
    rand_num = rn_a[j];
    occ_ack  = ack_a[j];
    occ_hit  = hit_a[j];
  endtask

  // Runs one spawn from IDLE; called #1 after a rising edge.
  task automatic do_spawn(input string nm, input int ex, input int ey, input bit efail,
                          input int jlast, input bit hold);
    spawn_req = 1'b1;
    @(posedge clk); #1;
    check({nm, " busy"}, 32'(spawn_busy), 1);
    check({nm, " valid_low"}, 32'(food_valid), 0);
    spawn_req = hold;
    drive_cycle(0);
    for (int j = 0; j <= jlast; j++) begin
      check($sformatf("%s occ_req[%0d]", nm, j), 32'(occ_req), 32'(chk_a[j]));
      @(posedge clk); #1;
      if (j == jlast) begin
        spawn_req = 1'b0;
        check({nm, " done"}, 32'(spawn_done), 1);
        check({nm, " fail"}, 32'(spawn_fail), 32'(efail));
        check({nm, " food_x"}, 32'(food_x), 32'(ex));
        check({nm, " food_y"}, 32'(food_y), 32'(ey));
        check({nm, " valid"}, 32'(food_valid), 1);
        check({nm, " idle"}, 32'(spawn_busy), 0);
        check({nm, " expired"}, 32'(food_expired), 0);
      end else begin
        check($sformatf("%s early_done[%0d]", nm, j), 32'(spawn_done), 0);
        drive_cycle(j + 1);
      end
    end
    @(posedge clk); #1;
    check({nm, " pulse_end"}, 32'(spawn_done), 0);
    for (int w = 0; w < 600 && spawn_busy; w++) begin
      @(posedge clk); #1;
    end
    if (spawn_busy) begin
      $display("FAIL %s: DUT stuck busy", nm);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "stuck");
    end
  endtask

  // Reference: walk the rand stream as draws; every out-of-range value or occupied
  // square is one rejection, and the MAX_TRIES-th rejection gives the fallback.
  task automatic model(output int ex, output int ey, output bit efail, output int jlast);
    int t, rej, cx, cy;
    t = 0; rej = 0; cx = 0; cy = 0;
    for (int j = 0; j < MAXJ; j++) chk_a[j] = 1'b0;
    while (1) begin
      while (rn_a[t] >= 40) begin
        t++; rej++;
        if (rej == 16) begin ex = 320; ey = 240; efail = 1; jlast = t - 1; return; end
      end
      cx = int'(rn_a[t]); t++;
      while (rn_a[t] >= 30) begin
        t++; rej++;
        if (rej == 16) begin ex = 320; ey = 240; efail = 1; jlast = t - 1; return; end
      end
      cy = int'(rn_a[t]); t++;
      while (!ack_a[t]) begin chk_a[t] = 1'b1; t++; end
      chk_a[t] = 1'b1;
      if (!hit_a[t]) begin ex = cx * 16; ey = cy * 16; efail = 0; jlast = t; return; end
      t++; rej++;
      if (rej == 16) begin ex = 320; ey = 240; efail = 1; jlast = t - 1; return; end
    end
  endtask

  initial begin
    int ex, ey, jl;
    bit ef;

    tbl[0] = '{rn:'{5, 7, 7, 7, 7, 7},       hitm:0, chkm:'h04, ex:80,  ey:112, fail:0, jlast:2,  hold:0};
    tbl[1] = '{rn:'{45, 5, 7, 7, 7, 7},      hitm:0, chkm:'h08, ex:80,  ey:112, fail:0, jlast:3,  hold:0};
    tbl[2] = '{rn:'{5, 7, 0, 3, 4, 4},       hitm:'h04, chkm:'h24, ex:48, ey:64, fail:0, jlast:5,  hold:0};
    tbl[3] = '{rn:'{511, 511, 511, 511, 511, 511}, hitm:0, chkm:0, ex:320, ey:240, fail:1, jlast:15, hold:0};
    tbl[4] = '{rn:'{39, 30, 29, 29, 29, 29}, hitm:0, chkm:'h08, ex:624, ey:464, fail:0, jlast:3,  hold:0};
    tbl[5] = '{rn:'{0, 0, 0, 0, 0, 0},       hitm:0, chkm:'h04, ex:0,   ey:0,   fail:0, jlast:2,  hold:1};
    tbl[6] = '{rn:'{40, 40, 12, 45, 30, 2},  hitm:0, chkm:'h40, ex:192, ey:32,  fail:0, jlast:6,  hold:1};

    repeat (2) @(posedge clk);
    #1;
    check("rst food_x", 32'(food_x), 320);
    check("rst food_y", 32'(food_y), 240);
    check("rst valid", 32'(food_valid), 1);
    check("rst busy", 32'(spawn_busy), 0);
    check("rst occ_req", 32'(occ_req), 0);
    check("rst occ_x", 32'(occ_x), 0);
    check("rst occ_y", 32'(occ_y), 0);
    check("rst pulses", 32'({spawn_done, spawn_fail, food_expired}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < MAXJ; j++) begin
        rn_a[j]  = 9'(tbl[i].rn[(j < 6) ? j : 5]);
        ack_a[j] = 1'b1;
        hit_a[j] = (j < 16) ? bit'((tbl[i].hitm >> j) & 1) : 1'b0;
        chk_a[j] = (j < 16) ? bit'((tbl[i].chkm >> j) & 1) : 1'b0;
      end
      do_spawn($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].fail, tbl[i].jlast, tbl[i].hold);
    end

    // Reset while waiting in CHECK aborts the spawn and keeps no request.
    spawn_req = 1'b1;
    @(posedge clk); #1;
    spawn_req = 1'b0; rand_num = 9'd5; occ_ack = 1'b0; occ_hit = 1'b0;
    @(posedge clk); #1;
    rand_num = 9'd7;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check("abort occ_req", 32'(occ_req), 1);
    check("abort occ_x", 32'(occ_x), 80);
    check("abort occ_y", 32'(occ_y), 112);
    rst_n = 1'b0;
    #1;
    check("abort food_x", 32'(food_x), 320);
    check("abort food_y", 32'(food_y), 240);
    check("abort valid", 32'(food_valid), 1);
    check("abort occ_req_low", 32'(occ_req), 0);
    check("abort busy", 32'(spawn_busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort no_retain", 32'(spawn_busy), 0);

    for (int r = 0; r < 30; r++) begin
      for (int j = 0; j < MAXJ; j++) begin
        rn_a[j]  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 45));
        ack_a[j] = (j >= 300) ? 1'b1 : bit'($urandom_range(0, 1));
        hit_a[j] = ($urandom_range(0, 2) == 0);
      end
      model(ex, ey, ef, jl);
      do_spawn($sformatf("rnd%0d", r), ex, ey, ef, jl, bit'($urandom_range(0, 1)));
    end

`ifdef FOOD_TIMEOUT_EN
    begin
      int n;
      n = 0;
      // One idle edge has already elapsed since publication, so the 100th lands at n=99.
      for (int k = 1; k <= 200 && n == 0; k++) begin
        @(posedge clk); #1;
        if (food_expired) n = k;
      end
      check("timeout cycle", 32'(n), 99);
      check("timeout respawn", 32'(spawn_busy), 1);
      check("timeout valid_low", 32'(food_valid), 0);
    end
`else
    repeat (150) @(posedge clk);
    #1;
    check("no timeout busy", 32'(spawn_busy), 0);
    check("no timeout expired", 32'(food_expired), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
